// File: rtl/ast_systolic_gemm_sv.v
// The ast_systolic_gemm_sv design source is rtl/ast_systolic_gemm_sv.sv.

// File: rtl/ast_systolic_gemm_sv.sv
// Output-stationary SIZE x SIZE signed GEMM with input skew, run FSM and row-serial drain; AST_GEMM_SAT_EN selects saturating accumulate.
// Latency: start accept to done = 1 + K + (2*SIZE-1) + SIZE cycles at full rate with out_ready high.
// Backpressure: in_ready only in STREAM (bubbles inject zeros); out_row/out_idx held while out_valid && !out_ready.
module ast_systolic_gemm_sv #(
    parameter int SIZE      = 4,
    parameter int DATAWIDTH = 14,
    parameter int ACCWIDTH  = 32,
    parameter int KWIDTH    = 10
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [KWIDTH-1:0]                  k_len,
    input  logic [SIZE-1:0][DATAWIDTH-1:0]     a_in,
    input  logic [SIZE-1:0][DATAWIDTH-1:0]     b_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [SIZE-1:0][ACCWIDTH-1:0]      out_row,
    output logic [$clog2(SIZE)-1:0]            out_idx,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
`ifdef AST_GEMM_SAT_EN
    output logic                               sat_flag,
`endif
    output logic                               done
);

    localparam int IW = $clog2(SIZE);
    localparam int FW = $clog2(2*SIZE);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [KWIDTH-1:0] k_lat, kcnt;
    logic [FW-1:0]     fcnt;
    logic [IW-1:0]     row;
    logic              start_acc, accept, row_acc, last_row;

    assign start_acc = (state == S_IDLE) && start;
    assign accept    = (state == S_STREAM) && in_valid;
    assign row_acc   = (state == S_DRAIN) && out_ready;
    assign last_row  = (row == IW'(SIZE-1));

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:   if (start) state_nxt = (k_len == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: begin
                in_ready = 1'b1;
                if (accept && kcnt == k_lat - KWIDTH'(1)) state_nxt = S_FLUSH;
            end
            S_FLUSH:  if (fcnt == FW'(2*SIZE-2)) state_nxt = S_DRAIN;
            S_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && last_row) state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_lat <= '0;
            kcnt  <= '0;
            fcnt  <= '0;
            row   <= '0;
            done  <= 1'b0;
        end else begin
            done <= row_acc && last_row;
            if (start_acc) begin
                k_lat <= k_len;
                kcnt  <= '0;
                fcnt  <= '0;
                row   <= '0;
            end else begin
                if (accept)             kcnt <= kcnt + KWIDTH'(1);
                if (state == S_FLUSH)   fcnt <= fcnt + FW'(1);
                if (row_acc)            row  <= last_row ? '0 : row + IW'(1);
            end
        end
    end

    // Non-accepted cycles inject zeros so the array can free-run every cycle.
    logic [SIZE-1:0][DATAWIDTH-1:0] a_inj, b_inj;
    logic [DATAWIDTH-1:0]           a_edge [SIZE];
    logic [DATAWIDTH-1:0]           b_edge [SIZE];

    assign a_inj = accept ? a_in : '0;
    assign b_inj = accept ? b_in : '0;

    for (genvar r = 0; r < SIZE; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign a_edge[r] = a_inj[r];
            assign b_edge[r] = b_inj[r];
        end else begin : g_delay
            logic [DATAWIDTH-1:0] a_d [r];
            logic [DATAWIDTH-1:0] b_d [r];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < r; i++) begin
                        a_d[i] <= '0;
                        b_d[i] <= '0;
                    end
                end else begin
                    a_d[0] <= a_inj[r];
                    b_d[0] <= b_inj[r];
                    for (int i = 1; i < r; i++) begin
                        a_d[i] <= a_d[i-1];
                        b_d[i] <= b_d[i-1];
                    end
                end
            end
            assign a_edge[r] = a_d[r-1];
            assign b_edge[r] = b_d[r-1];
        end
    end

    logic signed [DATAWIDTH-1:0] a_reg [SIZE][SIZE];
    logic signed [DATAWIDTH-1:0] b_reg [SIZE][SIZE];
    logic signed [ACCWIDTH-1:0]  acc   [SIZE][SIZE];
`ifdef AST_GEMM_SAT_EN
    logic [SIZE*SIZE-1:0]        sat_hit;
`endif

    for (genvar r = 0; r < SIZE; r++) begin : g_row
        for (genvar c = 0; c < SIZE; c++) begin : g_pe
            logic signed [DATAWIDTH-1:0]   a_left, b_up;
            logic signed [2*DATAWIDTH-1:0] prod;
            logic signed [ACCWIDTH-1:0]    addend, acc_nxt;

            if (c == 0) begin : g_al
                assign a_left = a_edge[r];
            end else begin : g_ai
                assign a_left = a_reg[r][c-1];
            end
            if (r == 0) begin : g_bt
                assign b_up = b_edge[c];
            end else begin : g_bi
                assign b_up = b_reg[r-1][c];
            end

            assign prod   = a_reg[r][c] * b_reg[r][c];
            assign addend = ACCWIDTH'(prod);
`ifdef AST_GEMM_SAT_EN
            logic signed [ACCWIDTH:0] sum_w;
            assign sum_w = (ACCWIDTH+1)'(acc[r][c]) + (ACCWIDTH+1)'(addend);
            assign sat_hit[r*SIZE+c] = (sum_w[ACCWIDTH] != sum_w[ACCWIDTH-1]);
            assign acc_nxt = !sat_hit[r*SIZE+c] ? sum_w[ACCWIDTH-1:0] :
                             sum_w[ACCWIDTH] ? {1'b1, {(ACCWIDTH-1){1'b0}}} :
                                               {1'b0, {(ACCWIDTH-1){1'b1}}};
`else
            assign acc_nxt = acc[r][c] + addend;
`endif

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_reg[r][c] <= '0;
                    b_reg[r][c] <= '0;
                    acc[r][c]   <= '0;
                end else begin
                    a_reg[r][c] <= a_left;
                    b_reg[r][c] <= b_up;
                    acc[r][c]   <= start_acc ? '0 : acc_nxt;
                end
            end
        end
    end

`ifdef AST_GEMM_SAT_EN
    logic sat_q;
    always_ff @(posedge clk) begin
        if (reset)          sat_q <= 1'b0;
        else if (start_acc) sat_q <= 1'b0;
        else if (|sat_hit)  sat_q <= 1'b1;
    end
    assign sat_flag = sat_q;
`endif

    always_comb begin
        out_row = '0;
        if (state == S_DRAIN) begin
            for (int c = 0; c < SIZE; c++) out_row[c] = acc[row][c];
        end
    end
    assign out_idx = row;

endmodule

// File: tb/tb_ast_systolic_gemm_sv.sv
// Randomised and directed runs of the GEMM engine against a plain-arithmetic matrix-product model.
module tb_ast_systolic_gemm_sv;
    localparam int SIZE = 4, DW = 14, AW = 28, KW = 10, MAXK = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset, start, in_valid, in_ready;
    logic                     out_valid, out_ready, busy, done;
    logic [KW-1:0]            k_len;
    logic [SIZE-1:0][DW-1:0]  a_in, b_in;
    logic [SIZE-1:0][AW-1:0]  out_row;
    logic [1:0]               out_idx;
`ifdef AST_GEMM_SAT_EN
    logic                     sat_flag;
`endif

    int     checks = 0, failures = 0;
    longint ma [SIZE][MAXK];
    longint mb [MAXK][SIZE];
    longint expc [SIZE][SIZE];
    bit     exp_sat;
    int     lat;

    ast_systolic_gemm_sv #(.SIZE(SIZE), .DATAWIDTH(DW), .ACCWIDTH(AW), .KWIDTH(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
        .out_row(out_row), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy),
`ifdef AST_GEMM_SAT_EN
        .sat_flag(sat_flag),
`endif
        .done(done)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint fit(input longint v);
        longint m;
`ifdef AST_GEMM_SAT_EN
        longint hi = (longint'(1) << (AW-1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
`else
        m = v & ((longint'(1) << AW) - 1);
        if (m >= (longint'(1) << (AW-1))) m = m - (longint'(1) << AW);
        return m;
`endif
    endfunction

    function automatic void model(input int k);
        longint s, a;
        exp_sat = 1'b0;
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                a = 0;
                for (int kk = 0; kk < k; kk++) begin
                    s = a + ma[r][kk] * mb[kk][c];
                    if (s != fit(s)) exp_sat = 1'b1;
                    a = fit(s);
                end
                expc[r][c] = a;
            end
    endfunction

    function automatic longint rnd();
        return longint'($urandom_range(0, 16383)) - 8192;
    endfunction

    function automatic void fill_random(input int k);
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < SIZE; i++) begin
                ma[i][kk] = rnd();
                mb[kk][i] = rnd();
            end
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_in_ready"}, longint'(in_ready), 0);
        chk({tag, "_out_valid"}, longint'(out_valid), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_out_idx"}, longint'(out_idx), 0);
        for (int c = 0; c < SIZE; c++)
            chk($sformatf("%s_out_row%0d", tag, c), longint'($signed(out_row[c])), 0);
    endtask

    // bub_mode: 0 full rate, 1 alternating valid, 2 random; bp_row < 0 disables backpressure.
    task automatic do_run(input string tag, input int k, input int bub_mode, input int bp_row,
                          input int bp_len, input bit poke_start, output int latency);
        int idx, cyc, nbub, got, held, t, exp_lat;
        bit v, rdy, seen;
        model(k);
        start = 1'b1;
        k_len = k[KW-1:0];
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; idx = 0; nbub = 0;
        while (idx < k) begin
            case (bub_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_valid = v;
            start = poke_start && (cyc == 1);
            for (int i = 0; i < SIZE; i++) begin
                a_in[i] = ma[i][idx][DW-1:0];
                b_in[i] = mb[idx][i][DW-1:0];
            end
            chk({tag, "_in_ready_stream"}, longint'(in_ready), 1);
            @(posedge clk); #1;
            cyc++;
            if (v) idx++; else nbub++;
        end
        in_valid = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
        got = 0; held = 0; t = 0;
        while (got < SIZE && t < 200) begin
            rdy = !(got == bp_row && held < bp_len);
            out_ready = rdy;
            chk({tag, "_in_ready_off"}, longint'(in_ready), 0);
            chk({tag, "_busy"}, longint'(busy), 1);
            seen = out_valid;
            if (out_valid) begin
                chk({tag, "_out_idx"}, longint'(out_idx), longint'(got));
                for (int c = 0; c < SIZE; c++)
                    chk($sformatf("%s_c%0d%0d", tag, got, c),
                        longint'($signed(out_row[c])), expc[got][c]);
                if (!rdy) held++;
            end
            @(posedge clk); #1;
            cyc++; t++;
            if (seen && rdy) got++;
        end
        out_ready = 1'b1;
        chk({tag, "_rows"}, longint'(got), SIZE);
        chk({tag, "_done"}, longint'(done), 1);
        chk({tag, "_idle"}, longint'(busy), 0);
        latency = cyc + 1;
        exp_lat = (k == 0) ? 1 + SIZE : 1 + k + (2*SIZE - 1) + SIZE + nbub;
        chk({tag, "_latency"}, longint'(latency), longint'(exp_lat + held));
`ifdef AST_GEMM_SAT_EN
        chk({tag, "_sat_flag"}, longint'(sat_flag), longint'(exp_sat));
`endif
        @(posedge clk); #1;
        chk({tag, "_done_once"}, longint'(done), 0);
        chk({tag, "_no_queued_run"}, longint'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
        a_in = '0; b_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        reset = 1'b0;

        for (int kk = 0; kk < 4; kk++)
            for (int i = 0; i < SIZE; i++) begin
                ma[i][kk] = (i == kk) ? 1 : 0;
                mb[kk][i] = kk * SIZE + i + 1;
            end
        do_run("ident", 4, 0, -1, 0, 1'b0, lat);
        chk("ident_row1_col2", expc[1][2], 7);
        do_run("bubble", 4, 1, -1, 0, 1'b0, lat);
        do_run("bp", 4, 0, 2, 3, 1'b0, lat);

        fill_random(5);
        do_run("busy_start", 5, 0, -1, 0, 1'b1, lat);
        do_run("kzero", 0, 0, -1, 0, 1'b0, lat);

        for (int kk = 0; kk < 8; kk++)
            for (int i = 0; i < SIZE; i++) begin
                ma[i][kk] = -8192;
                mb[kk][i] = -8192;
            end
        do_run("ovf", 8, 0, -1, 0, 1'b0, lat);

        for (int n = 0; n < 4; n++) begin
            int k;
            k = $urandom_range(1, 12);
            fill_random(k);
            do_run($sformatf("rand%0d", n), k, n % 3, $urandom_range(0, 3),
                   $urandom_range(0, 3), n[0], lat);
        end

        fill_random(6);
        start = 1'b1; k_len = 10'd6;
        @(posedge clk); #1;
        start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid = 1'b1;
            for (int i = 0; i < SIZE; i++) begin
                a_in[i] = ma[i][s][DW-1:0];
                b_in[i] = mb[s][i][DW-1:0];
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check_quiet("midreset");
        reset = 1'b0;
        fill_random(7);
        do_run("after_reset", 7, 2, 1, 2, 1'b0, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
